// File: rtl/cpu_dbg_pkg.sv
// Shared types and constants for the CPU debug register-dump logic.
package cpu_dbg_pkg;

  localparam int unsigned REG_ADDR_W   = 5;
  localparam int unsigned DEF_NUM_DUMP = 12;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_CNT_W    = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    LATCH,
    SEND,
    DONE
  } dump_state_e;

endpackage

// File: rtl/dump_trigger_cnt.sv
// Saturating cycle counter since reset release; raises auto_fire_c once per reset
// when the count reaches the programmed trigger value.
module dump_trigger_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             auto_en_i,
  input  logic [CNT_W-1:0] auto_count_i,
  output logic             auto_fire_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;
  logic             fired_q;

  assign auto_fire_c = auto_en_i && !fired_q && (cnt_q == auto_count_i);

  // fired_q latches on any firing, even one the dump FSM drops while busy
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q   <= '0;
      fired_q <= 1'b0;
    end else begin
      if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
      if (auto_fire_c)      fired_q <= 1'b1;
    end
  end

endmodule

// File: rtl/reg_dump_unit.sv
// Debug responder: reads registers 0..NUM_DUMP-1 through the register-file debug
// port and streams them out over a valid/ready interface.
module reg_dump_unit
  import cpu_dbg_pkg::*;
#(
  parameter int unsigned NUM_DUMP = DEF_NUM_DUMP,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  dump_req_i,
  input  logic                  auto_en_i,
  input  logic [CNT_W-1:0]      auto_count_i,
  output logic                  rf_rd_en_o,
  output logic [REG_ADDR_W-1:0] rf_addr_o,
  input  logic [DATA_W-1:0]     rf_data_i,
  output logic                  dout_valid_o,
  input  logic                  dout_ready_i,
  output logic [DATA_W-1:0]     dout_data_o,
  output logic [REG_ADDR_W-1:0] dout_idx_o,
  output logic                  dout_last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NUM_DUMP - 1);

  dump_state_e           state_q, state_d;
  logic [REG_ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  auto_fire_c;
  logic                  start_c;
  logic                  rd_en_d, valid_d, last_d, busy_d, done_d;
  logic [REG_ADDR_W-1:0] addr_d, out_idx_d;

  dump_trigger_cnt #(
    .CNT_W (CNT_W)
  ) u_trigger (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .auto_en_i    (auto_en_i),
    .auto_count_i (auto_count_i),
    .auto_fire_c  (auto_fire_c)
  );

  assign start_c     = dump_req_i | auto_fire_c;
  assign dout_data_o = data_q;

  // Next state, index and data; outputs are decoded from the next state so they
  // come straight out of flops aligned with the state they belong to.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    rd_en_d   = 1'b0;
    addr_d    = '0;
    valid_d   = 1'b0;
    last_d    = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    out_idx_d = '0;

    case (state_q)
      IDLE: begin
        if (start_c) begin
          idx_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = LATCH;
      LATCH: begin
        data_d  = rf_data_i;
        state_d = SEND;
      end
      SEND: begin
        if (dout_ready_i) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + REG_ADDR_W'(1);
            state_d = ISSUE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rd_en_d = (state_d == ISSUE);
    addr_d  = rd_en_d ? idx_d : '0;
    valid_d = (state_d == SEND);
    if (valid_d) begin
      out_idx_d = idx_d;
      last_d    = (idx_d == LAST_IDX);
    end
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      data_q       <= '0;
      rf_rd_en_o   <= 1'b0;
      rf_addr_o    <= '0;
      dout_valid_o <= 1'b0;
      dout_idx_o   <= '0;
      dout_last_o  <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      rf_rd_en_o   <= rd_en_d;
      rf_addr_o    <= addr_d;
      dout_valid_o <= valid_d;
      dout_idx_o   <= out_idx_d;
      dout_last_o  <= last_d;
      busy_o       <= busy_d;
      done_o       <= done_d;
    end
  end

endmodule

// File: tb/tb_reg_dump_unit.sv
// Randomized self-checking bench for reg_dump_unit: the bench plays the register
// file and checks the stream against a word-sequence scoreboard.
module tb_reg_dump_unit;
  import cpu_dbg_pkg::*;

  localparam int unsigned NUM = 12;
  localparam int unsigned DW  = 32;
  localparam int unsigned CW  = 16;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          dump_req_i = 1'b0;
  logic          auto_en_i = 1'b0;
  logic [CW-1:0] auto_count_i = '0;
  logic          rf_rd_en_o;
  logic [4:0]    rf_addr_o;
  logic [DW-1:0] rf_data_i = '0;
  logic          dout_valid_o;
  logic          dout_ready_i = 1'b0;
  logic [DW-1:0] dout_data_o;
  logic [4:0]    dout_idx_o;
  logic          dout_last_o;
  logic          busy_o;
  logic          done_o;

  always #5 clk_i = ~clk_i;

  reg_dump_unit #(.NUM_DUMP(NUM), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .dump_req_i   (dump_req_i),
    .auto_en_i    (auto_en_i),
    .auto_count_i (auto_count_i),
    .rf_rd_en_o   (rf_rd_en_o),
    .rf_addr_o    (rf_addr_o),
    .rf_data_i    (rf_data_i),
    .dout_valid_o (dout_valid_o),
    .dout_ready_i (dout_ready_i),
    .dout_data_o  (dout_data_o),
    .dout_idx_o   (dout_idx_o),
    .dout_last_o  (dout_last_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] rf [32];

  // scoreboard state: next expected word index plus handshake history
  int         exp_idx;
  bit         acc_last_prev, hold_prev, done_prev;
  logic [DW-1:0] hold_data;
  logic [4:0] hold_idx;
  int         words, dones, rds, k, first_rd_k, first_valid_k, done_k;
  bit         pend;
  logic [4:0] pend_addr;
  int         stall_idx = -1;
  int         stall_left = 0;
  int         req_at_idx = -1;
  bit         rdy_rand = 1'b0;
  bit         req_rand = 1'b0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock of bench activity, at the falling edge: RF model, checks, drive.
  task automatic cycle(input logic req);
    logic rdy;
    @(negedge clk_i);
    k++;
    rf_data_i = pend ? rf[pend_addr] : DW'($urandom);
    pend      = rf_rd_en_o;
    pend_addr = rf_addr_o;

    check_eq("done_pulse", done_o, acc_last_prev);
    if (done_prev) check_eq("idle_after_done", busy_o, 1'b0);
    if (done_o) begin
      dones++;
      done_k = k;
    end
    if (hold_prev) begin
      check_eq("hold_valid", dout_valid_o, 1'b1);
      check_eq("hold_data", dout_data_o, hold_data);
      check_eq("hold_idx", dout_idx_o, hold_idx);
    end
    if (rf_rd_en_o) begin
      check_eq("rd_addr", rf_addr_o, exp_idx);
      rds++;
      if (first_rd_k < 0) first_rd_k = k;
    end else begin
      check_eq("addr_idle", rf_addr_o, 0);
    end
    if (rf_rd_en_o || dout_valid_o || done_o) check_eq("busy", busy_o, 1'b1);
    if (dout_valid_o) begin
      check_eq("last_flag", dout_last_o, int'(dout_idx_o) == NUM - 1);
      if (first_valid_k < 0) first_valid_k = k;
    end

    rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (dout_valid_o && int'(dout_idx_o) == stall_idx && stall_left > 0) begin
      rdy = 1'b0;
      stall_left--;
    end
    dout_ready_i = rdy;
    dump_req_i   = req || (req_rand && $urandom_range(0, 3) == 0) ||
                   (dout_valid_o && int'(dout_idx_o) == req_at_idx);

    acc_last_prev = 1'b0;
    hold_prev     = 1'b0;
    done_prev     = done_o;
    if (dout_valid_o && rdy) begin
      check_eq("word_idx", dout_idx_o, exp_idx);
      check_eq("word_data", dout_data_o, rf[exp_idx]);
      words++;
      if (exp_idx == NUM - 1) begin
        acc_last_prev = 1'b1;
        exp_idx = 0;
      end else begin
        exp_idx++;
      end
    end else if (dout_valid_o) begin
      hold_prev = 1'b1;
      hold_data = dout_data_o;
      hold_idx  = dout_idx_o;
    end
  endtask

  task automatic clear_model();
    exp_idx = 0; acc_last_prev = 0; hold_prev = 0; done_prev = 0;
    words = 0; dones = 0; rds = 0; k = 0; pend = 0;
    first_rd_k = -1; first_valid_k = -1; done_k = -1;
  endtask

  // Asserts reset at a falling edge, checks the asynchronous clear, releases.
  task automatic do_reset(input logic en, input logic [CW-1:0] cnt);
    @(negedge clk_i);
    rst_i = 1'b0;
    dump_req_i = 1'b0;
    dout_ready_i = 1'b0;
    auto_en_i = en;
    auto_count_i = cnt;
    #1;
    check_eq("rst_ctl", {rf_rd_en_o, rf_addr_o, dout_valid_o, dout_idx_o,
                         dout_last_o, busy_o, done_o}, 0);
    check_eq("rst_data", dout_data_o, 0);
    clear_model();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic start_dump();
    cycle(1'b1);
    k = 0;
    first_rd_k = -1;
    first_valid_k = -1;
  endtask

  task automatic run_to_done(input int budget);
    int start;
    start = dones;
    for (int i = 0; i < budget && dones == start; i++) cycle(1'b0);
    check_eq("dump_done", dones - start, 1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = DW'(i * 3);

    // Directed dump, ready held high
    do_reset(1'b0, '0);
    start_dump();
    run_to_done(200);
    check_eq("t1_words", words, NUM);
    check_eq("t1_first_rd", first_rd_k, 1);
    check_eq("t1_first_valid", first_valid_k, 3);
    check_eq("t1_total", done_k, 3 * NUM + 1);
    repeat (3) cycle(1'b0);
    check_eq("t1_idle", busy_o, 1'b0);

    // Sink stalls for 4 cycles on word 2
    words = 0; dones = 0;
    stall_idx = 2; stall_left = 4;
    start_dump();
    run_to_done(200);
    check_eq("t2_stalled", stall_left, 0);
    check_eq("t2_words", words, NUM);
    check_eq("t2_total", done_k, 3 * NUM + 1 + 4);
    stall_idx = -1;

    // Auto trigger at count 5, fires only once per reset
    do_reset(1'b1, CW'(5));
    rdy_rand = 1'b1;
    run_to_done(200);
    check_eq("t3_first_rd", first_rd_k, 6);
    repeat (400) cycle(1'b0);
    check_eq("t3_dones", dones, 1);
    check_eq("t3_rds", rds, NUM);

    // Request during word 4 is ignored
    do_reset(1'b0, '0);
    req_at_idx = 4;
    start_dump();
    run_to_done(300);
    repeat (30) cycle(1'b0);
    check_eq("t4_words", words, NUM);
    check_eq("t4_dones", dones, 1);
    req_at_idx = -1;

    // Request and auto trigger in the same cycle: one dump
    do_reset(1'b1, CW'(8));
    repeat (7) cycle(1'b0);
    cycle(1'b1);
    run_to_done(300);
    repeat (60) cycle(1'b0);
    check_eq("t5_first_rd", first_rd_k, 9);
    check_eq("t5_words", words, NUM);
    check_eq("t5_dones", dones, 1);

    // Reset while word 7 waits in SEND: abort, no done, clean restart
    do_reset(1'b0, '0);
    rdy_rand = 1'b0;
    stall_idx = 7; stall_left = 1000;
    start_dump();
    for (int i = 0; i < 100 && !(dout_valid_o && dout_idx_o == 5'd7); i++) cycle(1'b0);
    check_eq("t6_reached_idx7", dout_idx_o, 7);
    do_reset(1'b0, '0);
    stall_idx = -1;
    repeat (5) cycle(1'b0);
    check_eq("t6_no_done", dones, 0);
    start_dump();
    run_to_done(200);
    check_eq("t6_words", words, NUM);

    // Random register contents, random ready, stray requests mid-dump
    rdy_rand = 1'b1;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      words = 0;
      start_dump();
      req_rand = 1'b1;
      run_to_done(400);
      req_rand = 1'b0;
      check_eq("rnd_words", words, NUM);
      repeat (2) cycle(1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
